// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE = 2'd0;
    localparam fetch_state_t WAIT = 2'd1;
    localparam fetch_state_t DROP = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_fifo
// Description : Small synchronous FIFO of fetched {instr, pc} entries.
//               Flush wins over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH  = 2,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  fetch_entry_t     i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    fetch_entry_t      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch unit: owns the PC, issues one outstanding
//               word fetch at a time and buffers responses toward decode.
//               Optional misaligned-redirect trap: IF_FETCH_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    output logic        o_misaligned,
`endif
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemReady,
    input  logic        i_imemValid,
    input  logic [31:0] i_imemInstr,
    input  logic        i_PCSrc,
    input  logic [31:0] i_branchTarget,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instrPC,
    input  logic        i_ready
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_req_pc;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_stop;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_wdata;
    fetch_entry_t     w_head;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic r_misaligned;
    logic w_trap_set;

    assign w_trap_set   = i_PCSrc & (i_branchTarget[1:0] != 2'b00);
    assign w_stop       = r_misaligned;
    assign o_misaligned = r_misaligned;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_misaligned <= 1'b0;
        end else if (w_trap_set) begin
            r_misaligned <= 1'b1;
        end
    end
`else
    assign w_stop = 1'b0;
`endif

    // Credit check on the count before any same-cycle pop keeps the FIFO
    // from ever overflowing with one fetch in flight.
    assign o_imemReq  = ~i_reset & ~i_PCSrc & ~w_stop
                      & (r_state == IDLE) & (w_count < c_DEPTH);
    assign o_imemAddr = r_pc;
    assign w_accept   = o_imemReq & i_imemReady;
    assign w_pop      = ~w_empty & i_ready;
    assign w_push     = i_imemValid & (r_state == WAIT) & ~i_PCSrc
                      & (~w_full | w_pop);
    assign w_wdata    = '{instr: i_imemInstr, pc: r_req_pc};

    assign o_valid    = ~w_empty;
    assign o_instr    = w_head.instr;
    assign o_instrPC  = w_head.pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            if (i_PCSrc) begin
                r_pc <= align_word(i_branchTarget);
            end else if (w_accept) begin
                r_pc     <= r_pc + PC_STEP;
                r_req_pc <= r_pc;
            end
            // A response landing with a redirect is consumed and discarded,
            // so the machine returns to IDLE rather than entering DROP.
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_imemValid) begin
                        r_state <= IDLE;
                    end else if (i_PCSrc) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (i_imemValid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (i_PCSrc),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam int          c_DEPTH    = 2;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_imemReq;
    logic [31:0] o_imemAddr;
    logic        i_imemReady;
    logic        i_imemValid;
    logic [31:0] i_imemInstr;
    logic        i_PCSrc;
    logic [31:0] i_branchTarget;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instrPC;
    logic        i_ready;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    if_fetch #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        .o_misaligned   (o_misaligned),
`endif
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_imemReq      (o_imemReq),
        .o_imemAddr     (o_imemAddr),
        .i_imemReady    (i_imemReady),
        .i_imemValid    (i_imemValid),
        .i_imemInstr    (i_imemInstr),
        .i_PCSrc        (i_PCSrc),
        .i_branchTarget (i_branchTarget),
        .o_valid        (o_valid),
        .o_instr        (o_instr),
        .o_instrPC      (o_instrPC),
        .i_ready        (i_ready)
    );

    always #5 i_clk = ~i_clk;

    int          tests = 0;
    int          fails = 0;
    // Reference model: memory has at most one request in flight; the decode
    // stream is a queue of PCs; a redirect empties it and restarts the PC.
    bit          pending;
    bit          pending_drop;
    logic [31:0] pending_addr;
    int          delay;
    logic [31:0] model_pc;
    logic [31:0] q[$];
    bit          model_trap;
    bit          rand_mode;
    int          fixed_lat;
    int          pops;
    logic [31:0] acc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_reset        = 1'b1;
        i_PCSrc        = 1'b0;
        i_branchTarget = '0;
        i_imemReady    = 1'b1;
        i_imemValid    = 1'b0;
        i_imemInstr    = '0;
        i_ready        = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_req", o_imemReq, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_instrPC", o_instrPC, 32'h0);
        chk("rst_addr", o_imemAddr, c_RESET_PC);
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        chk("rst_misaligned", o_misaligned, 1'b0);
`endif
        pending      = 1'b0;
        pending_drop = 1'b0;
        q.delete();
        model_pc     = c_RESET_PC;
        model_trap   = 1'b0;
        i_reset      = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input bit pcsrc, input logic [31:0] tgt, input bit dec_rdy);
        bit resp;
        bit acc;
        bit pop;
        bit misal;
        i_PCSrc        = pcsrc;
        i_branchTarget = tgt;
        i_ready        = dec_rdy;
        i_imemReady    = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        resp           = pending && (delay == 0);
        i_imemValid    = resp;
        i_imemInstr    = resp ? mem_word(pending_addr) : $urandom;
        #1;
        misal = 1'b0;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        misal = pcsrc && (tgt[1:0] != 2'b00);
        chk("misaligned", o_misaligned, model_trap);
`endif
        chk("imemAddr", o_imemAddr, model_pc);
        chk("imemReq", o_imemReq, !pending && (q.size() < c_DEPTH) && !pcsrc && !model_trap);
        chk("valid", o_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instrPC", o_instrPC, q[0]);
            chk("instr", o_instr, mem_word(q[0]));
        end
        acc = o_imemReq && i_imemReady;
        pop = o_valid && dec_rdy;
        if (acc) acc_log.push_back(o_imemAddr);

        if (pop && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
        end
        if (resp) begin
            if (!pending_drop && !pcsrc) q.push_back(pending_addr);
            pending = 1'b0;
        end
        if (pcsrc) begin
            q.delete();
            if (pending) pending_drop = 1'b1;
            model_pc = {tgt[31:2], 2'b00};
            if (misal) model_trap = 1'b1;
        end
        if (acc) begin
            pending      = 1'b1;
            pending_drop = 1'b0;
            pending_addr = model_pc;
            model_pc     = model_pc + 32'd4;
            delay        = rand_mode ? int'($urandom_range(0, 3)) : fixed_lat;
        end else if (pending) begin
            delay--;
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        bit          found;
        logic [31:0] tgt;
        pops      = 0;
        rand_mode = 1'b0;
        fixed_lat = 0;
        do_reset();

        // Decode stalled: two entries buffer, then requests stop at 0x108.
        repeat (10) cycle(1'b0, 32'h0, 1'b0);
        chk("stall_req", o_imemReq, 1'b0);
        chk("stall_pc", o_imemAddr, 32'h0000_0108);
        chk("stall_head", o_instrPC, 32'h0000_0100);
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        chk("order0", acc_log[0], 32'h0000_0100);
        chk("order1", acc_log[1], 32'h0000_0104);
        chk("order2", acc_log[2], 32'h0000_0108);

        // Redirect while a fetch is in flight; its response follows a cycle later.
        fixed_lat = 1;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending && delay == 1 && !pending_drop) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b1);
        end
        chk("find_wait", found, 1'b1);
        acc_log.delete();
        cycle(1'b1, 32'h0000_0200, 1'b1);
        chk("redir_valid", o_valid, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);
        chk("redir_addr", acc_log[0], 32'h0000_0200);

        // Redirect in the same cycle as the response.
        fixed_lat = 0;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending && delay == 0) found = 1'b1;
            else cycle(1'b0, 32'h0, 1'b1);
        end
        chk("find_resp", found, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b1);
        acc_log.delete();
        cycle(1'b0, 32'h0, 1'b1);
        chk("same_req_n", acc_log.size(), 1);
        chk("same_req_addr", acc_log[0], 32'h0000_0200);

        // PC wraps past the top of the address space.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        acc_log.delete();
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_top", acc_log[0], 32'hFFFF_FFFC);
        chk("wrap_zero", acc_log[1], 32'h0000_0000);

        // Misaligned redirect target.
        acc_log.delete();
        cycle(1'b1, 32'h0000_0202, 1'b1);
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        chk("trap_flag", o_misaligned, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        chk("trap_noreq", acc_log.size(), 0);
        do_reset();
`else
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        chk("misal_addr", acc_log[0], 32'h0000_0200);
`endif

        // Randomised traffic: memory readiness, latency, decode stalls, redirects.
        rand_mode = 1'b1;
        pops      = 0;
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            cycle($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 3) != 0);
        end
        chk("liveness", pops > 200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
